mpu_table_writer: RTL and testbench
===================================

MPU_TABLE_WRITER -- requirements
Module: mpu_table_writer

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, memory size in 32-bit words.
REQ-002 SHALL have parameter MPU_START_ADDR, default 768, word address of the MPU table base.
REQ-003 SHALL have parameter MPU_ITEM_NUM, default 16, number of table entries.
REQ-004 SHALL have parameter MPU_ITEM_LEN, default 5, words per entry: pc_lo, pc_hi, data_lo, data_hi, attr.
REQ-005 SHALL have parameter VERIFY_EN, default 1; when 1, every entry write is read back and checked.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port cfg_valid  input  1  command present.
REQ-009 SHALL have port cfg_ready  output  1  command accepted when cfg_valid and cfg_ready are both high at a clock edge.
REQ-010 SHALL have port cfg_clear  input  1  when 1, the command is clear-all and the entry fields are ignored.
REQ-011 SHALL have port cfg_index  input  5  entry index.
REQ-012 SHALL have ports cfg_pc_lo, cfg_pc_hi, cfg_data_lo, cfg_data_hi, cfg_attr  input  32 each  entry words.
REQ-013 SHALL have port mem_wen  output  4  byte write enables.
REQ-014 SHALL have port mem_addr  output  22  word address.
REQ-015 SHALL have port mem_wdata  output  32  write data.
REQ-016 SHALL have port mem_rdata  input  32  read data; valid one cycle after mem_addr is presented with mem_wen=0.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port status  output  2  result: 0 OK, 1 bad range, 2 bad index, 3 verify mismatch; held until the next done.
REQ-019 SHALL have port reload_req  output  1  one-cycle pulse telling the MPU to refetch its cache.

Function
REQ-020 SHALL implement the FSM states IDLE, CHECK, WRITE, VERIFY, CLEAR and DONE.
REQ-021 SHALL drive cfg_ready=1 only in IDLE; on accept at edge T, latch all cfg_* fields and enter CHECK.
REQ-022 SHALL compute base = MPU_START_ADDR + index*MPU_ITEM_LEN in 22 bits.
REQ-023 SHALL treat CHECK as the cycle after accept, with these priorities: clear -> CLEAR; index >= MPU_ITEM_NUM -> status 2; pc_lo > pc_hi or data_lo > data_hi (unsigned) -> status 1; otherwise -> WRITE.
REQ-024 SHALL, on a CHECK failure, go straight to DONE with no memory write.
REQ-025 SHALL, in WRITE, drive mem_wen=4'b1111, mem_addr=base+k and mem_wdata=word k for k=0..4 on consecutive cycles (T+2..T+6).
REQ-026 SHALL, in VERIFY (VERIFY_EN=1), use two cycles per word k=0..4: cycle 1 drives mem_wen=0 and mem_addr=base+k; cycle 2 compares mem_rdata with word k. The first mismatch sets status 3 and goes to DONE immediately.
REQ-027 SHALL, in CLEAR, write 32'h0 with mem_wen=4'b1111 to MPU_START_ADDR+0 .. MPU_START_ADDR+MPU_ITEM_NUM*MPU_ITEM_LEN-1 in order, one word per cycle, without verify.
REQ-028 SHALL, in DONE, hold for one cycle with done=1; reload_req=1 only if status=0; then return to IDLE.
REQ-029 SHALL meet this latency from accept edge T to the done cycle: entry with verify T+17; entry without verify T+7; clear T+2+80; CHECK failure T+2.
REQ-030 SHALL drive mem_wen=0 in every state except WRITE and CLEAR.
REQ-031 SHALL assert no write with address >= MEM_WORDS; a computed address out of range yields status 2 with no write.
REQ-032 SHALL ignore cfg_valid outside IDLE; commands are never queued.

Reset
REQ-033 SHALL, while resetn=0 at a clock edge, take state IDLE, cfg_ready=0, done=0, reload_req=0, status=0, mem_wen=0, mem_addr=0 and mem_wdata=0.
REQ-034 SHALL drive cfg_ready=1 on the first cycle after resetn returns to 1.
REQ-035 SHALL, on reset mid-WRITE or mid-CLEAR, force mem_wen=0 from the next edge and issue no done or reload_req for the aborted command.

Verification
REQ-036 SHALL cover: index 3, pc 0x100..0x1FF, data 0x400..0x4FF, attr 0x3, one-cycle-latency memory model -> writes to 783..787 at T+2..T+6, done at T+17 with status 0, one reload_req pulse.
REQ-037 SHALL cover: index 16 -> done at T+2, status 2, mem_wen never nonzero, no reload_req.
REQ-038 SHALL cover: pc_lo=0x200, pc_hi=0x100 -> done at T+2, status 1, no write.
REQ-039 SHALL cover: memory model returns data_lo^1 on the read-back of word 2 -> status 3, done after the word 2 compare, no reload_req, words 3 and 4 not read.
REQ-040 SHALL cover: clear-all -> 80 zero writes to 768..847 in order, done at T+82, status 0, reload_req pulse.
REQ-041 SHALL cover: resetn low at T+4 of an entry write -> mem_wen=0 from the next edge, no done, cfg_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/mpu_table_writer.sv
//------------------------------------------------------------------------------
// Module      : mpu_table_writer
// Description : Writes, optionally read-back-verifies, or clears MPU table entries
//               held in a word-addressed memory, then requests an MPU reload.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mpu_table_writer #(
    parameter int MEM_WORDS      = 1024,
    parameter int MPU_START_ADDR = 768,
    parameter int MPU_ITEM_NUM   = 16,
    parameter int MPU_ITEM_LEN   = 5,
    parameter int VERIFY_EN      = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_clear,
    input  logic [4:0]  cfg_index,
    input  logic [31:0] cfg_pc_lo,
    input  logic [31:0] cfg_pc_hi,
    input  logic [31:0] cfg_data_lo,
    input  logic [31:0] cfg_data_hi,
    input  logic [31:0] cfg_attr,
    output logic [3:0]  mem_wen,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic [1:0]  status,
    output logic        reload_req
);

    localparam int TOTAL_WORDS = MPU_ITEM_NUM * MPU_ITEM_LEN;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] WRITE  = 3'd2;
    localparam logic [2:0] VERIFY = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [1:0]  status_next;
    logic        ready_en;
    logic        lat_clear;
    logic [4:0]  lat_index;
    logic [31:0] lat_pc_lo;
    logic [31:0] lat_pc_hi;
    logic [31:0] lat_data_lo;
    logic [31:0] lat_data_hi;
    logic [31:0] lat_attr;
    logic [21:0] cnt;
    logic        phase;
    logic [21:0] base;
    logic [21:0] last_addr;
    logic [31:0] cur_word;
    logic        last_word;
    logic        last_clear;

    assign base       = 22'(MPU_START_ADDR) + 22'(lat_index) * 22'(MPU_ITEM_LEN);
    assign last_addr  = base + 22'(MPU_ITEM_LEN - 1);
    assign last_word  = (cnt == 22'(MPU_ITEM_LEN - 1));
    assign last_clear = (cnt == 22'(TOTAL_WORDS - 1));

    always_comb begin
        cur_word = lat_attr;
        case (cnt[2:0])
            3'd0:    cur_word = lat_pc_lo;
            3'd1:    cur_word = lat_pc_hi;
            3'd2:    cur_word = lat_data_lo;
            3'd3:    cur_word = lat_data_hi;
            default: cur_word = lat_attr;
        endcase
    end

    // State register plus command latch, word counter and result status.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            ready_en    <= 1'b0;
            status      <= 2'd0;
            cnt         <= 22'd0;
            phase       <= 1'b0;
            lat_clear   <= 1'b0;
            lat_index   <= 5'd0;
            lat_pc_lo   <= 32'd0;
            lat_pc_hi   <= 32'd0;
            lat_data_lo <= 32'd0;
            lat_data_hi <= 32'd0;
            lat_attr    <= 32'd0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            status   <= status_next;
            if (state == IDLE && cfg_valid && ready_en) begin
                lat_clear   <= cfg_clear;
                lat_index   <= cfg_index;
                lat_pc_lo   <= cfg_pc_lo;
                lat_pc_hi   <= cfg_pc_hi;
                lat_data_lo <= cfg_data_lo;
                lat_data_hi <= cfg_data_hi;
                lat_attr    <= cfg_attr;
            end
            if (state_next != state) begin
                cnt   <= 22'd0;
                phase <= 1'b0;
            end else if (state == WRITE || state == CLEAR) begin
                cnt <= cnt + 22'd1;
            end else if (state == VERIFY) begin
                phase <= ~phase;
                if (phase) begin
                    cnt <= cnt + 22'd1;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        status_next = status;
        case (state)
            IDLE: begin
                if (cfg_valid && ready_en) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (lat_clear) begin
                    if (MPU_START_ADDR + TOTAL_WORDS > MEM_WORDS) begin
                        state_next  = DONE;
                        status_next = 2'd2;
                    end else begin
                        state_next = CLEAR;
                    end
                end else if ({27'd0, lat_index} >= 32'(MPU_ITEM_NUM)) begin
                    state_next  = DONE;
                    status_next = 2'd2;
                end else if ({10'd0, last_addr} >= 32'(MEM_WORDS)) begin
                    state_next  = DONE;
                    status_next = 2'd2;
                end else if (lat_pc_lo > lat_pc_hi || lat_data_lo > lat_data_hi) begin
                    state_next  = DONE;
                    status_next = 2'd1;
                end else begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    if (VERIFY_EN != 0) begin
                        state_next = VERIFY;
                    end else begin
                        state_next  = DONE;
                        status_next = 2'd0;
                    end
                end
            end
            VERIFY: begin
                // Second cycle of each word: read data for base+cnt is now valid.
                if (phase) begin
                    if (mem_rdata != cur_word) begin
                        state_next  = DONE;
                        status_next = 2'd3;
                    end else if (last_word) begin
                        state_next  = DONE;
                        status_next = 2'd0;
                    end
                end
            end
            CLEAR: begin
                if (last_clear) begin
                    state_next  = DONE;
                    status_next = 2'd0;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = 1'b0;
        mem_wen    = 4'b0000;
        mem_addr   = 22'd0;
        mem_wdata  = 32'd0;
        done       = 1'b0;
        reload_req = 1'b0;
        case (state)
            IDLE:   cfg_ready = ready_en;
            WRITE: begin
                mem_wen   = 4'b1111;
                mem_addr  = base + cnt;
                mem_wdata = cur_word;
            end
            VERIFY: mem_addr = base + cnt;
            CLEAR: begin
                mem_wen  = 4'b1111;
                mem_addr = 22'(MPU_START_ADDR) + cnt;
            end
            DONE: begin
                done       = 1'b1;
                reload_req = (status == 2'd0);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mpu_table_writer.sv
//------------------------------------------------------------------------------
// Module      : tb_mpu_table_writer
// Description : Scoreboard bench for mpu_table_writer with a one-cycle memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mpu_table_writer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_clear = 1'b0;
    logic [4:0]  cfg_index = 5'd0;
    logic [31:0] cfg_pc_lo = 32'd0;
    logic [31:0] cfg_pc_hi = 32'd0;
    logic [31:0] cfg_data_lo = 32'd0;
    logic [31:0] cfg_data_hi = 32'd0;
    logic [31:0] cfg_attr = 32'd0;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        done;
    logic [1:0]  status;
    logic        reload_req;

    mpu_table_writer dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_clear  (cfg_clear),
        .cfg_index  (cfg_index),
        .cfg_pc_lo  (cfg_pc_lo),
        .cfg_pc_hi  (cfg_pc_hi),
        .cfg_data_lo(cfg_data_lo),
        .cfg_data_hi(cfg_data_hi),
        .cfg_attr   (cfg_attr),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .status     (status),
        .reload_req (reload_req)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read, optional single-bit corruption on one address.
    logic [31:0] mem [0:1023];
    logic        corrupt = 1'b0;
    logic [21:0] corrupt_addr = 22'd0;
    int          watch_reads = 0;
    always @(posedge clk) begin
        if (mem_wen == 4'hf) mem[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:0]] ^ ((corrupt && mem_addr == corrupt_addr) ? 32'd1 : 32'd0);
        if (mem_wen == 4'h0 && (mem_addr == 22'd786 || mem_addr == 22'd787)) watch_reads <= watch_reads + 1;
    end

    typedef struct {
        bit          is_done;
        logic [21:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
        logic        rl;
        int          c;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        checks = checks + 1;
        if (ok) passes = passes + 1;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic push_write(input logic [21:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.st = 2'd0; e.rl = 1'b0; e.c = c;
        q.push_back(e);
    endtask

    task automatic push_done(input logic [1:0] st, input logic rl, input int c);
        exp_t e;
        e.is_done = 1'b1; e.addr = 22'd0; e.data = 32'd0; e.st = st; e.rl = rl; e.c = c;
        q.push_back(e);
    endtask

    // Monitor: every write or done the DUT presents must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (mem_wen != 4'h0) begin
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_write", $sformatf("got wen=%h addr=%0d at cyc %0d, required none", mem_wen, mem_addr, cyc));
            end else begin
                e = q.pop_front();
                chk(!e.is_done && mem_wen == 4'hf && mem_addr == e.addr && mem_wdata == e.data && cyc == e.c, "write",
                    $sformatf("got wen=%h addr=%0d data=%h cyc=%0d, required done=%0d addr=%0d data=%h cyc=%0d",
                              mem_wen, mem_addr, mem_wdata, cyc, e.is_done, e.addr, e.data, e.c));
            end
        end
        if (done) begin
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_done", $sformatf("got done status=%0d at cyc %0d, required none", status, cyc));
            end else begin
                e = q.pop_front();
                chk(e.is_done && status == e.st && reload_req == e.rl && cyc == e.c, "done",
                    $sformatf("got status=%0d reload=%0d cyc=%0d, required done=%0d status=%0d reload=%0d cyc=%0d",
                              status, reload_req, cyc, e.is_done, e.st, e.rl, e.c));
            end
        end
        if (reload_req && !done) chk(1'b0, "stray_reload", $sformatf("got reload_req=1 without done at cyc %0d, required 0", cyc));
    end

    // Wait for ready, then present one command; returns the accept edge number.
    task automatic issue(input logic clr, input logic [4:0] idx, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4, output int t);
        int n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) chk(1'b0, "ready_timeout", "got cfg_ready=0 for 50 cycles, required 1");
        t = cyc + 1;
        cfg_clear = clr; cfg_index = idx;
        cfg_pc_lo = w0; cfg_pc_hi = w1; cfg_data_lo = w2; cfg_data_hi = w3; cfg_attr = w4;
        cfg_valid = 1'b1;
    endtask

    task automatic release_valid();
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input logic [1:0] st_hold);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(q.size() == 0, "drain", $sformatf("got %0d pending events, required 0", q.size()));
        repeat (3) @(negedge clk);
        chk(status == st_hold, "status_hold", $sformatf("got status=%0d, required %0d", status, st_hold));
    endtask

    initial begin
        int t;
        logic [31:0] w [0:4];
        w[0] = 32'h100; w[1] = 32'h1FF; w[2] = 32'h400; w[3] = 32'h4FF; w[4] = 32'h3;

        repeat (2) @(negedge clk);
        chk(cfg_ready == 1'b0 && done == 1'b0 && reload_req == 1'b0, "reset_ctrl",
            $sformatf("got ready=%0d done=%0d reload=%0d, required 0 0 0", cfg_ready, done, reload_req));
        chk(status == 2'd0, "reset_status", $sformatf("got %0d, required 0", status));
        chk(mem_wen == 4'h0 && mem_addr == 22'd0 && mem_wdata == 32'd0, "reset_mem",
            $sformatf("got wen=%h addr=%0d data=%h, required 0 0 0", mem_wen, mem_addr, mem_wdata));
        resetn = 1'b1;
        @(negedge clk);
        chk(cfg_ready == 1'b1, "ready_after_reset", $sformatf("got %0d, required 1", cfg_ready));

        // Entry 3 with verify; a clear command offered mid-flight must be ignored.
        issue(1'b0, 5'd3, w[0], w[1], w[2], w[3], w[4], t);
        for (int k = 0; k < 5; k++) push_write(22'(783 + k), w[k], t + 1 + k);
        push_done(2'd0, 1'b1, t + 16);
        release_valid();
        cfg_clear = 1'b1; cfg_valid = 1'b1;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b0; cfg_clear = 1'b0;
        drain(2'd0);

        // Index out of table.
        issue(1'b0, 5'd16, w[0], w[1], w[2], w[3], w[4], t);
        push_done(2'd2, 1'b0, t + 1);
        release_valid();
        drain(2'd2);

        // Inverted pc range.
        issue(1'b0, 5'd1, 32'h200, 32'h100, w[2], w[3], w[4], t);
        push_done(2'd1, 1'b0, t + 1);
        release_valid();
        drain(2'd1);

        // Read-back of word 2 corrupted: stops after that compare.
        corrupt = 1'b1; corrupt_addr = 22'd785;
        issue(1'b0, 5'd3, w[0], w[1], w[2], w[3], w[4], t);
        for (int k = 0; k < 5; k++) push_write(22'(783 + k), w[k], t + 1 + k);
        push_done(2'd3, 1'b0, t + 12);
        release_valid();
        watch_reads = 0;
        drain(2'd3);
        chk(watch_reads == 0, "no_read_w3_w4", $sformatf("got %0d reads of 786/787, required 0", watch_reads));
        corrupt = 1'b0;

        // Clear-all.
        issue(1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, t);
        for (int k = 0; k < 80; k++) push_write(22'(768 + k), 32'd0, t + 1 + k);
        push_done(2'd0, 1'b1, t + 81);
        release_valid();
        drain(2'd0);

        // Reset during an entry write: only the first three writes land.
        issue(1'b0, 5'd5, 32'h10, 32'h20, 32'h30, 32'h40, 32'h5, t);
        push_write(22'd793, 32'h10, t + 1);
        push_write(22'd794, 32'h20, t + 2);
        push_write(22'd795, 32'h30, t + 3);
        release_valid();
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk(mem_wen == 4'h0 && done == 1'b0 && cfg_ready == 1'b0, "abort_reset",
            $sformatf("got wen=%h done=%0d ready=%0d, required 0 0 0", mem_wen, done, cfg_ready));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk(cfg_ready == 1'b1, "ready_after_abort", $sformatf("got %0d, required 1", cfg_ready));
        chk(q.size() == 0, "abort_writes", $sformatf("got %0d pending writes, required 0", q.size()));
        repeat (20) @(negedge clk);
        chk(status == 2'd0, "abort_status", $sformatf("got %0d, required 0", status));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
